sobel_sdram_wr_buf: RTL

Downstream neighbour of the Sobel top stage. Accepts its 16-bit per-pixel output stream (sdram_wr_en / sdram_wr_data) into a FWFT FIFO. Packs the stream into fixed-length SDRAM write bursts and issues them to the SDRAM controller write port with request/ack/data-request handshakes. Generates linear frame addresses with wrap-around and re-aligns to the frame base on each frame_start.

---
 rtl/sobel_wr_pkg.sv | 15 +
 rtl/sobel_sdram_wr_buf_if.sv | 24 ++
 rtl/sync_fifo_fwft.sv | 66 ++++++
 rtl/sobel_sdram_wr_buf.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/sobel_wr_pkg.sv
// Shared types and constants for the Sobel SDRAM write buffer.
package sobel_wr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_BURST,
    ST_WAIT_DONE
  } wr_state_e;

  localparam int PIX_W           = 16;
  localparam int DEF_BURST_LEN   = 8;
  localparam int DEF_FRAME_WORDS = 786432;

endpackage

// File: rtl/sobel_sdram_wr_buf_if.sv
// SDRAM controller write-port bundle; master = write buffer, slave = controller.
interface sobel_sdram_wr_buf_if #(
  parameter int ADDR_W = 24
);
  import sobel_wr_pkg::*;

  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_ack;
  logic              wr_data_req;
  logic [PIX_W-1:0]  wr_data;
  logic              wr_done;

  modport master (
    output wr_req, wr_addr, wr_data,
    input  wr_ack, wr_data_req, wr_done
  );

  modport slave (
    input  wr_req, wr_addr, wr_data,
    output wr_ack, wr_data_req, wr_done
  );

endinterface

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO with a registered head; push while full is accepted
// only together with a pop. The head holds its last value once the FIFO drains.
module sync_fifo_fwft #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         din_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [LVL_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == LVL_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wptr_d = wptr_q + PTR_W'(do_push);
    rptr_d = rptr_q + PTR_W'(do_pop);
    cnt_d  = cnt_q + LVL_W'(do_push) - LVL_W'(do_pop);
    head_d = head_q;
    // When the pop leaves nothing behind, the incoming word becomes the head directly.
    if (cnt_d != '0) begin
      if (cnt_q == LVL_W'(do_pop)) head_d = din_i;
      else                         head_d = mem_q[rptr_d];
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= din_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      head_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      head_q <= head_d;
    end
  end

  assign dout_o  = head_q;
  assign level_o = cnt_q;

endmodule

// File: rtl/sobel_sdram_wr_buf.sv
// Buffers the Sobel pixel stream and issues fixed-length SDRAM write bursts at
// linear frame addresses. Define SOBEL_WR_STAT_EN to add drop/burst counters.
module sobel_sdram_wr_buf
  import sobel_wr_pkg::*;
#(
  parameter int                BURST_LEN   = DEF_BURST_LEN,
  parameter int                FIFO_DEPTH  = 32,
  parameter int                ADDR_W      = 24,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int                FRAME_WORDS = DEF_FRAME_WORDS
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          sdram_wr_en,
  input  logic [PIX_W-1:0]              sdram_wr_data,
  input  logic                          frame_start,
  sobel_sdram_wr_buf_if.master          wr_if,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow
`ifdef SOBEL_WR_STAT_EN
  ,
  output logic [15:0]                   drop_cnt,
  output logic [15:0]                   burst_cnt
`endif
);

  localparam int                LVL_W     = $clog2(FIFO_DEPTH) + 1;
  localparam int                BEAT_W    = $clog2(BURST_LEN);
  localparam logic [LVL_W-1:0]  BURST_LVL = LVL_W'(BURST_LEN);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
  localparam logic [ADDR_W:0]   STEP      = (ADDR_W + 1)'(BURST_LEN);
  localparam logic [ADDR_W:0]   END_ADDR  = {1'b0, BASE_ADDR} + (ADDR_W + 1)'(FRAME_WORDS);

  wr_state_e         state_q, state_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   addr_inc;
  logic              realign_q, realign_d;
  logic              ovf_q;
  logic              fifo_full, fifo_empty, pop, drop;
  logic [LVL_W-1:0]  level;

  assign pop      = (state_q == ST_BURST) && wr_if.wr_data_req && !fifo_empty;
  assign drop     = sdram_wr_en && fifo_full && !pop;
  assign addr_inc = {1'b0, addr_q} + STEP;

  sync_fifo_fwft #(
    .WIDTH (PIX_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (sdram_wr_en),
    .din_i   (sdram_wr_data),
    .pop_i   (pop),
    .dout_o  (wr_if.wr_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (level)
  );

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    addr_d    = addr_q;
    realign_d = realign_q;
    unique case (state_q)
      ST_IDLE: begin
        if (realign_q) begin
          addr_d    = BASE_ADDR;
          realign_d = 1'b0;
        end
        if (level >= BURST_LVL) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (wr_if.wr_ack) begin
          state_d = ST_BURST;
          beat_d  = '0;
        end
      end
      ST_BURST: begin
        if (pop) begin
          beat_d = beat_q + 1'b1;
          if (beat_q == LAST_BEAT) state_d = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (wr_if.wr_done) begin
          addr_d  = (addr_inc == END_ADDR) ? BASE_ADDR : addr_inc[ADDR_W-1:0];
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Realignment is deferred to IDLE so an in-flight burst keeps its address.
    if (frame_start) realign_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      beat_q    <= '0;
      addr_q    <= BASE_ADDR;
      realign_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      addr_q    <= addr_d;
      realign_q <= realign_d;
      if (drop) ovf_q <= 1'b1;
    end
  end

  assign wr_if.wr_req  = (state_q == ST_REQ);
  assign wr_if.wr_addr = addr_q;
  assign fifo_level    = level;
  assign overflow      = ovf_q;

`ifdef SOBEL_WR_STAT_EN
  logic [15:0] drop_cnt_q, burst_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt_q  <= '0;
      burst_cnt_q <= '0;
    end else begin
      if (drop && (drop_cnt_q != 16'hFFFF)) drop_cnt_q <= drop_cnt_q + 16'd1;
      if (frame_start)
        burst_cnt_q <= '0;
      else if ((state_q == ST_WAIT_DONE) && wr_if.wr_done)
        burst_cnt_q <= burst_cnt_q + 16'd1;
    end
  end

  assign drop_cnt  = drop_cnt_q;
  assign burst_cnt = burst_cnt_q;
`endif

endmodule
